fu_exec_unit: RTL and testbench
===============================

Name: fu_exec_unit

Overview:
- Functional-unit endpoint of the issue interface: receives one issue bundle (PC, optype, aluNum, operands, imm, dest tag, ROB number) for a single ALU/address slot.
- Executes it over a fixed latency, holds the result until writeback accepts it, and drives the FU ready flag back to the issue queue.
- One instance per FU slot (ALU0, ALU1, ALU2/memory-address).

Parameters:
- FU_ID, 0, slot number this unit serves; compared against aluNum_in.
- LATENCY, 1, cycles spent in EXEC (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous squash of in-flight op.
- issue_valid_in  input  1  issue bundle valid this cycle.
- PC_in  input  32  instruction PC.
- optype_in  input  4  1=ADD 2=ADDI 3=LUI 4=ORI 5=XOR 6=SRAI 7=LB 8=LW 9=SB 10=SW.
- aluNum_in  input  2  target slot.
- srcReg1_data_in  input  32  operand 1.
- srcReg2_data_in  input  32  operand 2 / store data.
- imm_in  input  32  immediate (LUI imm pre-shifted).
- destReg_in  input  6  physical dest tag.
- ROBNum_in  input  6  ROB entry.
- FU_ready_out  output  1  unit can accept an issue this cycle.
- wb_valid_out  output  1  result held for writeback.
- wb_ack_in  input  1  writeback consumes result.
- wb_result_out  output  32  ALU result or effective address.
- wb_store_data_out  output  32  operand 2 for SB/SW, else 0.
- wb_is_mem_out  output  1  optype 7..10.
- wb_is_store_out  output  1  optype 9/10.
- wb_PC_out  output  32  PC.
- wb_destReg_out  output  6  dest tag.
- wb_ROBNum_out  output  6  ROB entry.
- err_out  output  1  sticky protocol/illegal-op flag.

Behaviour:
- States: IDLE, EXEC, DONE. All state changes on posedge clk, except rst, which acts asynchronously.
- Reset values: state IDLE, all wb_* outputs 0, err_out 0, FU_ready_out 1 (combinational: state==IDLE).
- Issue accept: requires issue_valid_in & FU_ready_out & aluNum_in==FU_ID. Captures the bundle, loads counter = LATENCY-1, goes to EXEC.
- Issue while not ready: bundle ignored, err_out set.
- aluNum_in != FU_ID with issue_valid_in: bundle ignored, err_out set.
- EXEC: counter decrements each cycle. When counter==0, the result registers load and state goes to DONE. wb_valid_out is first high after edge N+LATENCY, where N is the accept edge.
- Results (32-bit, wrap on overflow):
  - ADD = s1+s2
  - ADDI = s1+imm
  - LUI = imm
  - ORI = s1|imm
  - XOR = s1^s2
  - SRAI = s1 >>> imm[4:0] (arithmetic)
  - LB/LW/SB/SW = s1+imm (effective address)
  - Optype 0 or 11..15: result 0, err_out set, still written back so the ROB entry retires.
- DONE: wb_valid_out=1; all wb_* outputs stable until wb_ack_in. An edge with wb_ack_in=1 returns to IDLE and clears wb_valid_out. wb_ack_in without wb_valid_out is ignored.
- flush_in has priority over every other event:
  - any state goes to IDLE at next edge;
  - wb_valid_out goes to 0;
  - a simultaneous issue is dropped without setting err_out.
- err_out clears only on rst.
- rst mid-EXEC/DONE: op discarded immediately, outputs return to reset values.

Optional Feature:
- Macro FU_BYPASS_EN.
- Defined: FU_ready_out = (state==IDLE) | (state==DONE & wb_ack_in). An issue accepted in the same cycle as the ack goes straight to EXEC, giving back-to-back throughput of one op per LATENCY+1 cycles.
- Undefined: FU_ready_out = (state==IDLE) only, so one idle bubble follows each writeback.

Test Plan:
- Reset, then ADD s1=5 s2=7 ROB=3 with LATENCY=1 -> wb_valid high after the 1st edge post-accept; result=12, ROBNum=3; FU_ready_out=0 until wb_ack, 1 the cycle after.
- SRAI s1=0x80000000 imm=4 -> result=0xF8000000; ADDI s1=0xFFFFFFFF imm=1 -> result=0.
- SW s1=0x100 imm=8 s2=0xDEAD -> result=0x108, store_data=0xDEAD, is_mem=1, is_store=1; hold wb_ack low 5 cycles -> all outputs unchanged.
- Issue while in EXEC, or aluNum != FU_ID -> bundle ignored, err_out=1 and stays 1 until rst.
- flush_in during EXEC with LATENCY=4 -> wb_valid never rises, IDLE next cycle; flush together with wb_ack in DONE -> IDLE, no error.
- FU_BYPASS_EN defined: wb_ack and a new issue in the same cycle -> new op accepted, next wb_valid after LATENCY edges; undefined: issue ignored and err_out=1.

Source files
------------

// File: rtl/fu_exec_unit.sv
// Single-slot execute unit: accepts an issue bundle, produces result after LATENCY edges, holds it until wb_ack_in.
// Issue is back-pressured through FU_ready_out; define FU_BYPASS_EN to accept a new op in the same cycle as the ack.
module fu_exec_unit #(
    parameter int FU_ID   = 0,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_in,
    input  logic        issue_valid_in,
    input  logic [31:0] PC_in,
    input  logic [3:0]  optype_in,
    input  logic [1:0]  aluNum_in,
    input  logic [31:0] srcReg1_data_in,
    input  logic [31:0] srcReg2_data_in,
    input  logic [31:0] imm_in,
    input  logic [5:0]  destReg_in,
    input  logic [5:0]  ROBNum_in,
    output logic        FU_ready_out,
    output logic        wb_valid_out,
    input  logic        wb_ack_in,
    output logic [31:0] wb_result_out,
    output logic [31:0] wb_store_data_out,
    output logic        wb_is_mem_out,
    output logic        wb_is_store_out,
    output logic [31:0] wb_PC_out,
    output logic [5:0]  wb_destReg_out,
    output logic [5:0]  wb_ROBNum_out,
    output logic        err_out
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] s1_q, s2_q, imm_q, pc_q;
    logic [5:0]  dest_q, rob_q;

    logic        id_match, accept, bad_issue;
    logic [31:0] res;
    logic        illegal, is_mem, is_store;

`ifdef FU_BYPASS_EN
    assign FU_ready_out = (state == IDLE) | ((state == DONE) & wb_ack_in);
`else
    assign FU_ready_out = (state == IDLE);
`endif

    // A flush silently drops any issue presented in the same cycle.
    assign id_match  = (aluNum_in == 2'(FU_ID));
    assign accept    = issue_valid_in & ~flush_in & FU_ready_out & id_match;
    assign bad_issue = issue_valid_in & ~flush_in & ~(FU_ready_out & id_match);

    always_comb begin
        res     = 32'd0;
        illegal = 1'b0;
        case (op_q)
            4'd1:                 res = s1_q + s2_q;
            4'd2:                 res = s1_q + imm_q;
            4'd3:                 res = imm_q;
            4'd4:                 res = s1_q | imm_q;
            4'd5:                 res = s1_q ^ s2_q;
            4'd6:                 res = $unsigned($signed(s1_q) >>> imm_q[4:0]);
            4'd7, 4'd8, 4'd9, 4'd10: res = s1_q + imm_q;
            default:              illegal = 1'b1;
        endcase
        is_mem   = (op_q >= 4'd7) && (op_q <= 4'd10);
        is_store = (op_q == 4'd9) || (op_q == 4'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            op_q              <= 4'd0;
            s1_q              <= 32'd0;
            s2_q              <= 32'd0;
            imm_q             <= 32'd0;
            pc_q              <= 32'd0;
            dest_q            <= 6'd0;
            rob_q             <= 6'd0;
            wb_valid_out      <= 1'b0;
            wb_result_out     <= 32'd0;
            wb_store_data_out <= 32'd0;
            wb_is_mem_out     <= 1'b0;
            wb_is_store_out   <= 1'b0;
            wb_PC_out         <= 32'd0;
            wb_destReg_out    <= 6'd0;
            wb_ROBNum_out     <= 6'd0;
            err_out           <= 1'b0;
        end else begin
            if (bad_issue)
                err_out <= 1'b1;
            if (accept) begin
                op_q   <= optype_in;
                s1_q   <= srcReg1_data_in;
                s2_q   <= srcReg2_data_in;
                imm_q  <= imm_in;
                pc_q   <= PC_in;
                dest_q <= destReg_in;
                rob_q  <= ROBNum_in;
                cnt    <= CNT_INIT;
            end
            if (flush_in) begin
                state        <= IDLE;
                wb_valid_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) state <= EXEC;
                    EXEC: begin
                        if (cnt == 4'd0) begin
                            // Illegal ops still write back (result 0) so the ROB entry can retire.
                            wb_valid_out      <= 1'b1;
                            wb_result_out     <= res;
                            wb_store_data_out <= is_store ? s2_q : 32'd0;
                            wb_is_mem_out     <= is_mem;
                            wb_is_store_out   <= is_store;
                            wb_PC_out         <= pc_q;
                            wb_destReg_out    <= dest_q;
                            wb_ROBNum_out     <= rob_q;
                            if (illegal)
                                err_out <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    DONE: if (wb_ack_in) begin
                        wb_valid_out <= 1'b0;
                        state        <= accept ? EXEC : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fu_exec_unit.sv
// Directed and randomized bench for fu_exec_unit; expected values come from a behavioural model of the ISA rules.
module tb_fu_exec_unit;
    localparam int FU_ID = 1;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, wb_ack;
    logic [31:0] pc, s1, s2, imm;
    logic [3:0]  optype;
    logic [1:0]  alu_num;
    logic [5:0]  dest, rob;
    logic        ready, wb_valid, wb_is_mem, wb_is_store, err;
    logic [31:0] wb_result, wb_store_data, wb_pc;
    logic [5:0]  wb_dest, wb_rob;

    int passed = 0;
    int total  = 0;

    logic [31:0] e_res, e_sd, e_pc;
    logic        e_mem, e_st;
    logic [5:0]  e_dest, e_rob;

    fu_exec_unit #(.FU_ID(FU_ID), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .flush_in(flush), .issue_valid_in(issue_valid),
        .PC_in(pc), .optype_in(optype), .aluNum_in(alu_num),
        .srcReg1_data_in(s1), .srcReg2_data_in(s2), .imm_in(imm),
        .destReg_in(dest), .ROBNum_in(rob), .FU_ready_out(ready),
        .wb_valid_out(wb_valid), .wb_ack_in(wb_ack), .wb_result_out(wb_result),
        .wb_store_data_out(wb_store_data), .wb_is_mem_out(wb_is_mem),
        .wb_is_store_out(wb_is_store), .wb_PC_out(wb_pc),
        .wb_destReg_out(wb_dest), .wb_ROBNum_out(wb_rob), .err_out(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] i);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd1: return a + b;
            4'd2: return a + i;
            4'd3: return i;
            4'd4: return a | i;
            4'd5: return a ^ b;
            4'd6: return sa >>> i[4:0];
            4'd7, 4'd8, 4'd9, 4'd10: return a + i;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [5:0] d, input logic [5:0] r);
        pc = $urandom; optype = op; alu_num = 2'(FU_ID);
        s1 = a; s2 = b; imm = i; dest = d; rob = r;
        issue_valid = 1'b1;
        e_res  = model_res(op, a, b, i);
        e_st   = (op == 4'd9) || (op == 4'd10);
        e_mem  = (op >= 4'd7) && (op <= 4'd10);
        e_sd   = e_st ? b : 32'd0;
        e_pc   = pc; e_dest = d; e_rob = r;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] i, input logic [5:0] d, input logic [5:0] r);
        drive(op, a, b, i, d, r);
        chk("ready_at_issue", 32'(ready), 32'd1);
        cyc();
        issue_valid = 1'b0;
        chk("busy_after_accept", 32'(ready), 32'd0);
    endtask

    task automatic wait_wb(input int exp_k);
        int k = 0;
        while (!wb_valid && k < LAT + 4) begin
            cyc();
            k++;
        end
        chk("wb_latency", 32'(k), 32'(exp_k));
    endtask

    task automatic check_wb(input string tag);
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "_result"}, wb_result, e_res);
        chk({tag, "_store_data"}, wb_store_data, e_sd);
        chk({tag, "_is_mem"}, 32'(wb_is_mem), 32'(e_mem));
        chk({tag, "_is_store"}, 32'(wb_is_store), 32'(e_st));
        chk({tag, "_pc"}, wb_pc, e_pc);
        chk({tag, "_dest"}, 32'(wb_dest), 32'(e_dest));
        chk({tag, "_rob"}, 32'(wb_rob), 32'(e_rob));
    endtask

    task automatic do_ack();
        wb_ack = 1'b1;
        cyc();
        wb_ack = 1'b0;
        chk("valid_after_ack", 32'(wb_valid), 32'd0);
        chk("ready_after_ack", 32'(ready), 32'd1);
    endtask

    task automatic expect_no_wb(input string tag);
        int hi = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            if (wb_valid) hi++;
            cyc();
        end
        chk(tag, 32'(hi), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #7;
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; flush = 0; issue_valid = 0; wb_ack = 0;
        pc = 0; optype = 0; alu_num = 0; s1 = 0; s2 = 0; imm = 0; dest = 0; rob = 0;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_result", wb_result, 32'd0);
        chk("rst_rob", 32'(wb_rob), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        cyc();

        start_op(4'd1, 32'd5, 32'd7, 32'd0, 6'd9, 6'd3);
        wait_wb(LAT);
        check_wb("add");
        chk("ready_in_done", 32'(ready), 32'd0);
        do_ack();

        start_op(4'd6, 32'h8000_0000, 32'd0, 32'd4, 6'd1, 6'd4);
        wait_wb(LAT); check_wb("srai"); do_ack();
        start_op(4'd2, 32'hFFFF_FFFF, 32'd0, 32'd1, 6'd2, 6'd5);
        wait_wb(LAT); check_wb("addi_wrap"); do_ack();

        start_op(4'd10, 32'h100, 32'hDEAD, 32'd8, 6'd3, 6'd6);
        wait_wb(LAT);
        for (int h = 0; h < 5; h++) begin
            check_wb("sw_hold");
            cyc();
        end
        do_ack();

        for (int n = 0; n < 24; n++) begin
            int hold;
            start_op(4'($urandom_range(1, 10)), $urandom, $urandom, $urandom,
                     6'($urandom), 6'($urandom));
            wait_wb(LAT);
            hold = $urandom_range(0, 2);
            for (int h = 0; h <= hold; h++) begin
                check_wb("rand");
                cyc();
            end
            do_ack();
            chk("rand_err", 32'(err), 32'd0);
        end

        start_op(4'd13, 32'd1, 32'd2, 32'd3, 6'd7, 6'd8);
        wait_wb(LAT); check_wb("illegal_op");
        chk("illegal_err", 32'(err), 32'd1);
        do_ack();
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err), 32'd0);

        drive(4'd1, 32'd1, 32'd1, 32'd0, 6'd1, 6'd1);
        alu_num = 2'(FU_ID + 1);
        cyc();
        issue_valid = 1'b0;
        chk("wrong_slot_err", 32'(err), 32'd1);
        chk("wrong_slot_ready", 32'(ready), 32'd1);
        expect_no_wb("wrong_slot_no_wb");
        do_reset();

        start_op(4'd5, 32'hF0F0, 32'h0FF0, 32'd0, 6'd10, 6'd11);
        pc = 32'h1234; s1 = 32'd99; rob = 6'd0; issue_valid = 1'b1;
        cyc();
        issue_valid = 1'b0;
        chk("busy_issue_err", 32'(err), 32'd1);
        wait_wb(LAT - 1);
        check_wb("busy_issue_orig");
        do_ack();
        chk("busy_err_sticky", 32'(err), 32'd1);
        do_reset();

        start_op(4'd1, 32'd3, 32'd4, 32'd0, 6'd1, 6'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_exec_idle", 32'(ready), 32'd1);
        expect_no_wb("flush_exec_no_wb");
        chk("flush_exec_err", 32'(err), 32'd0);

        drive(4'd1, 32'd3, 32'd4, 32'd0, 6'd1, 6'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0; issue_valid = 1'b0;
        chk("flush_issue_dropped", 32'(ready), 32'd1);
        chk("flush_issue_err", 32'(err), 32'd0);

        start_op(4'd4, 32'hA000, 32'd0, 32'h5, 6'd3, 6'd3);
        wait_wb(LAT);
        flush = 1'b1; wb_ack = 1'b1;
        cyc();
        flush = 1'b0; wb_ack = 1'b0;
        chk("flush_ack_valid", 32'(wb_valid), 32'd0);
        chk("flush_ack_ready", 32'(ready), 32'd1);
        chk("flush_ack_err", 32'(err), 32'd0);

        start_op(4'd3, 32'd0, 32'd0, 32'hABCD_0000, 6'd4, 6'd12);
        wait_wb(LAT);
        check_wb("pre_bypass");
        wb_ack = 1'b1;
        drive(4'd8, 32'h2000, 32'd0, 32'h10, 6'd5, 6'd13);
`ifdef FU_BYPASS_EN
        chk("bypass_ready", 32'(ready), 32'd1);
        cyc();
        wb_ack = 1'b0; issue_valid = 1'b0;
        chk("bypass_valid_drop", 32'(wb_valid), 32'd0);
        wait_wb(LAT);
        check_wb("bypass_op");
        chk("bypass_err", 32'(err), 32'd0);
        do_ack();
`else
        chk("nobypass_ready", 32'(ready), 32'd0);
        cyc();
        wb_ack = 1'b0; issue_valid = 1'b0;
        chk("nobypass_err", 32'(err), 32'd1);
        chk("nobypass_idle", 32'(ready), 32'd1);
        expect_no_wb("nobypass_no_wb");
`endif
        do_reset();

        start_op(4'd1, 32'd10, 32'd20, 32'd0, 6'd6, 6'd7);
        wait_wb(LAT);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(wb_valid), 32'd0);
        chk("async_rst_result", wb_result, 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        cyc();
        expect_no_wb("after_rst_no_wb");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
